atom_2r2w_ctrl: RTL and testbench
=================================

Name: atom_2r2w_ctrl

Overview:
- Initiator-side controller that owns the ports of a 2-read/2-write SRAM atom (NUMADDR x BITDATA, SRAM_DELAY read latency).
- Performs the reset-time initialization sweep through both write ports and holds off user traffic until the sweep finishes.
- Forwards user reads and writes to the atom and resolves same-address write collisions.
- Re-times returned read data with a per-port valid strobe.

Parameters:
- NUMADDR, 8, number of memory words.
- BITADDR, 3, address width; requires 2^BITADDR >= NUMADDR.
- BITDATA, 1, data width.
- SRAM_DELAY, 0, atom read latency in cycles (>= 0).
- RSTINIT, 0, 1 = write an init pattern after reset; 0 = skip the sweep.
- RSTSTRT, 0, init value of word 0.
- RSTINCR, 0, init value step per address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ready  out  1  controller accepting user requests.
- read_0 / read_1  in  1  user read request.
- rd_adr_0 / rd_adr_1  in  BITADDR  user read address.
- rd_vld_0 / rd_vld_1  out  1  read data valid.
- rd_dout_0 / rd_dout_1  out  BITDATA  read data.
- write_2 / write_3  in  1  user write request.
- wr_adr_2 / wr_adr_3  in  BITADDR  user write address.
- wr_din_2 / wr_din_3  in  BITDATA  user write data.
- oor_err  out  1  one-cycle pulse: a request addressed >= NUMADDR was dropped.
- mem_read_0 / mem_read_1  out  1  atom read enable.
- mem_rd_adr_0 / mem_rd_adr_1  out  BITADDR  atom read address.
- mem_rd_dout_0 / mem_rd_dout_1  in  BITDATA  atom read data.
- mem_write_2 / mem_write_3  out  1  atom write enable.
- mem_wr_adr_2 / mem_wr_adr_3  out  BITADDR  atom write address.
- mem_wr_din_2 / mem_wr_din_3  out  BITDATA  atom write data.

Behaviour:
- States: INIT and READY.
  - Async reset sets state = INIT (RSTINIT=1) or READY (RSTINIT=0), init_cnt = 0, and clears the valid pipelines and oor_err.
- While rst is high:
  - ready = 0.
  - All mem_read_* / mem_write_* = 0.
  - rd_vld_* = 0.
- INIT, cycle k (k = 0 .. ceil(NUMADDR/2)-1):
  - mem_write_2 = 1, adr 2k, data (RSTSTRT + 2k*RSTINCR) truncated to BITDATA.
  - mem_write_3 = 1, adr 2k+1, data (RSTSTRT + (2k+1)*RSTINCR) truncated.
  - If NUMADDR is odd, mem_write_3 = 0 in the last cycle.
  - Arithmetic is done in 32 bits, then truncated.
  - At the end of the last cycle, move to READY. The sweep lasts exactly ceil(NUMADDR/2) cycles.
- ready = (state == READY) && !rst, decoded from the registered state.
- User requests while ready = 0 are discarded: not forwarded, no rd_vld, no oor_err.
- READY, all combinational, zero added latency:
  - Each user read/write whose address < NUMADDR is forwarded to the matching mem_* port in the same cycle.
  - Out-of-range requests are suppressed and pulse oor_err (registered, asserted the next cycle).
  - Write collision (write_2 && write_3 && wr_adr_2 == wr_adr_3): mem_write_2 is suppressed and port 3 wins.
  - Reads and writes to the same address in the same cycle return the old data (atom semantics; no bypass).
- Read return:
  - rd_vld_n = the forwarded mem_read_n delayed SRAM_DELAY cycles. With SRAM_DELAY = 0 it is combinational.
  - rd_dout_n = mem_rd_dout_n when rd_vld_n = 1, else 0.
- Back-to-back reads every cycle are supported; the pipeline is SRAM_DELAY deep with no stalls.
- Reset asserted mid-INIT or mid-read:
  - Outputs idle immediately.
  - In-flight rd_vld is lost.
  - The sweep restarts from address 0 after release.
- Unused mem_* address/data outputs are driven 0 when their enable is 0.

Test Plan:
1. NUMADDR=5, BITDATA=4, RSTINIT=1, RSTSTRT=3, RSTINCR=2; release reset -> writes adr0/1 = 3/5, then adr2/3 = 7/9, then adr4 = 11 with mem_write_3 = 0; ready rises after 3 cycles. Read all 5 addresses -> data 3,5,7,9,11.
2. RSTINIT=1, RSTSTRT=14, RSTINCR=1, BITDATA=4 -> adr2 receives 0 (wrap: 16 mod 16).
3. SRAM_DELAY=2; read_0 at adr 3 on cycles t, t+1 -> rd_vld_0 high on t+2 and t+3 carrying adr-3 data; rd_dout_0 = 0 on other cycles.
4. write_2 (adr 6, 0xA) and write_3 (adr 6, 0x5) in the same cycle -> only mem_write_3 asserted; a later read of adr 6 returns 0x5.
5. NUMADDR=5: read_1 at adr 7 -> mem_read_1 = 0, oor_err pulses 1 cycle, no rd_vld_1. A request during INIT -> dropped silently.
6. Assert rst on INIT cycle 1 for 1 cycle -> outputs idle during reset; after release the sweep restarts at adr 0/1 and ready rises ceil(NUMADDR/2) cycles later.

Source files
------------

// File: rtl/atom_2r2w_ctrl_if.sv
// atom_2r2w_ctrl_if: user request/return bundle plus the SRAM atom port bundle for the 2R2W controller.
// Latency: none, wires only.
// Backpressure: none on the atom side; the user side observes ready and drops requests while it is low.
interface atom_2r2w_ctrl_if #(
  parameter int BITADDR = 3,
  parameter int BITDATA = 1
) ();

  // user side
  logic               ready;
  logic               read_0;
  logic               read_1;
  logic [BITADDR-1:0] rd_adr_0;
  logic [BITADDR-1:0] rd_adr_1;
  logic               rd_vld_0;
  logic               rd_vld_1;
  logic [BITDATA-1:0] rd_dout_0;
  logic [BITDATA-1:0] rd_dout_1;
  logic               write_2;
  logic               write_3;
  logic [BITADDR-1:0] wr_adr_2;
  logic [BITADDR-1:0] wr_adr_3;
  logic [BITDATA-1:0] wr_din_2;
  logic [BITDATA-1:0] wr_din_3;
  logic               oor_err;

  // atom side
  logic               mem_read_0;
  logic               mem_read_1;
  logic [BITADDR-1:0] mem_rd_adr_0;
  logic [BITADDR-1:0] mem_rd_adr_1;
  logic [BITDATA-1:0] mem_rd_dout_0;
  logic [BITDATA-1:0] mem_rd_dout_1;
  logic               mem_write_2;
  logic               mem_write_3;
  logic [BITADDR-1:0] mem_wr_adr_2;
  logic [BITADDR-1:0] mem_wr_adr_3;
  logic [BITDATA-1:0] mem_wr_din_2;
  logic [BITDATA-1:0] mem_wr_din_3;

  // controller view
  modport master (
    output ready, rd_vld_0, rd_vld_1, rd_dout_0, rd_dout_1, oor_err,
    output mem_read_0, mem_read_1, mem_rd_adr_0, mem_rd_adr_1,
    output mem_write_2, mem_write_3, mem_wr_adr_2, mem_wr_adr_3, mem_wr_din_2, mem_wr_din_3,
    input  read_0, read_1, rd_adr_0, rd_adr_1,
    input  write_2, write_3, wr_adr_2, wr_adr_3, wr_din_2, wr_din_3,
    input  mem_rd_dout_0, mem_rd_dout_1
  );

  // environment view: user agent plus atom
  modport slave (
    input  ready, rd_vld_0, rd_vld_1, rd_dout_0, rd_dout_1, oor_err,
    input  mem_read_0, mem_read_1, mem_rd_adr_0, mem_rd_adr_1,
    input  mem_write_2, mem_write_3, mem_wr_adr_2, mem_wr_adr_3, mem_wr_din_2, mem_wr_din_3,
    output read_0, read_1, rd_adr_0, rd_adr_1,
    output write_2, write_3, wr_adr_2, wr_adr_3, wr_din_2, wr_din_3,
    output mem_rd_dout_0, mem_rd_dout_1
  );

endinterface

// File: rtl/atom_2r2w_ctrl.sv
// atom_2r2w_ctrl: reset-time init sweep, request forwarding and write-collision control for a 2R2W SRAM atom.
// Latency: requests forwarded combinationally; rd_vld trails mem_read by SRAM_DELAY cycles; oor_err one cycle later.
// Backpressure: none; requests are dropped (never stalled) while ready is low, reads pipeline without stalls.
module atom_2r2w_ctrl #(
  parameter int NUMADDR    = 8,
  parameter int BITADDR    = 3,
  parameter int BITDATA    = 1,
  parameter int SRAM_DELAY = 0,
  parameter int RSTINIT    = 0,
  parameter int RSTSTRT    = 0,
  parameter int RSTINCR    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  atom_2r2w_ctrl_if.master       io_bus
);

  // Two words are written per sweep cycle, one per write port.
  localparam int          INIT_CYC  = (NUMADDR + 1) / 2;
  localparam int          CNTW      = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(INIT_CYC - 1);
  localparam logic [31:0] NUM_U     = 32'(NUMADDR);
  localparam logic [31:0] STRT_U    = 32'(RSTSTRT);
  localparam logic [31:0] INCR_U    = 32'(RSTINCR);

  typedef enum logic {ST_INIT, ST_READY} state_t;
  localparam state_t RST_STATE = (RSTINIT != 0) ? ST_INIT : ST_READY;

  state_t            r_state;
  logic [CNTW-1:0]   r_init_cnt;
  logic              r_oor;

  logic              w_ready;
  logic              w_init;
  logic              w_rd_ok_0, w_rd_ok_1;
  logic              w_rd_oor_0, w_rd_oor_1;
  logic              w_wr_coll;
  logic              w_wr_ok_2, w_wr_ok_3;
  logic              w_wr_oor_2, w_wr_oor_3;
  logic              w_rd_vld_0, w_rd_vld_1;
  logic [31:0]       w_init_idx_2, w_init_idx_3;
  logic [31:0]       w_init_val_2, w_init_val_3;
  logic              w_init_wr_3;

  function automatic logic in_range(input logic [BITADDR-1:0] adr);
    return 32'(adr) < NUM_U;
  endfunction

  // Both qualifiers include !rst so every enable idles the moment reset asserts.
  assign w_ready = (r_state == ST_READY) && !rst;
  assign w_init  = (r_state == ST_INIT)  && !rst;

  assign io_bus.ready = w_ready;

  // Request qualification: only forwarded while ready and in range.
  assign w_rd_ok_0  = w_ready && io_bus.read_0  &&  in_range(io_bus.rd_adr_0);
  assign w_rd_ok_1  = w_ready && io_bus.read_1  &&  in_range(io_bus.rd_adr_1);
  assign w_rd_oor_0 = w_ready && io_bus.read_0  && !in_range(io_bus.rd_adr_0);
  assign w_rd_oor_1 = w_ready && io_bus.read_1  && !in_range(io_bus.rd_adr_1);
  assign w_wr_oor_2 = w_ready && io_bus.write_2 && !in_range(io_bus.wr_adr_2);
  assign w_wr_oor_3 = w_ready && io_bus.write_3 && !in_range(io_bus.wr_adr_3);

  // Same-address double write: port 3 wins, port 2 is squashed.
  assign w_wr_coll = io_bus.write_2 && io_bus.write_3 && (io_bus.wr_adr_2 == io_bus.wr_adr_3);
  assign w_wr_ok_2 = w_ready && io_bus.write_2 && in_range(io_bus.wr_adr_2) && !w_wr_coll;
  assign w_wr_ok_3 = w_ready && io_bus.write_3 && in_range(io_bus.wr_adr_3);

  // Sweep addresses/values computed in 32 bits and truncated on the way out.
  assign w_init_idx_2 = 32'(r_init_cnt) << 1;
  assign w_init_idx_3 = w_init_idx_2 + 32'd1;
  assign w_init_val_2 = STRT_U + w_init_idx_2 * INCR_U;
  assign w_init_val_3 = STRT_U + w_init_idx_3 * INCR_U;
  assign w_init_wr_3  = w_init && (w_init_idx_3 < NUM_U);

  // Sweep sequencer: one word pair per cycle, then hand over to user traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_init_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == LAST_CNT) begin
            r_state    <= ST_READY;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + CNTW'(1);
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Flag any dropped out-of-range request on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_oor <= 1'b0;
    else     r_oor <= w_rd_oor_0 | w_rd_oor_1 | w_wr_oor_2 | w_wr_oor_3;
  end

  assign io_bus.oor_err = r_oor;

  // Read ports: pass through when qualified, otherwise drive zeros.
  assign io_bus.mem_read_0   = w_rd_ok_0;
  assign io_bus.mem_read_1   = w_rd_ok_1;
  assign io_bus.mem_rd_adr_0 = w_rd_ok_0 ? io_bus.rd_adr_0 : '0;
  assign io_bus.mem_rd_adr_1 = w_rd_ok_1 ? io_bus.rd_adr_1 : '0;

  // Write ports: sweep owns them during INIT, user traffic afterwards.
  always_comb begin
    io_bus.mem_write_2  = 1'b0;
    io_bus.mem_wr_adr_2 = '0;
    io_bus.mem_wr_din_2 = '0;
    io_bus.mem_write_3  = 1'b0;
    io_bus.mem_wr_adr_3 = '0;
    io_bus.mem_wr_din_3 = '0;
    if (w_init) begin
      io_bus.mem_write_2  = 1'b1;
      io_bus.mem_wr_adr_2 = BITADDR'(w_init_idx_2);
      io_bus.mem_wr_din_2 = BITDATA'(w_init_val_2);
      if (w_init_wr_3) begin
        io_bus.mem_write_3  = 1'b1;
        io_bus.mem_wr_adr_3 = BITADDR'(w_init_idx_3);
        io_bus.mem_wr_din_3 = BITDATA'(w_init_val_3);
      end
    end else begin
      if (w_wr_ok_2) begin
        io_bus.mem_write_2  = 1'b1;
        io_bus.mem_wr_adr_2 = io_bus.wr_adr_2;
        io_bus.mem_wr_din_2 = io_bus.wr_din_2;
      end
      if (w_wr_ok_3) begin
        io_bus.mem_write_3  = 1'b1;
        io_bus.mem_wr_adr_3 = io_bus.wr_adr_3;
        io_bus.mem_wr_din_3 = io_bus.wr_din_3;
      end
    end
  end

  // Read-valid tracking matches the atom latency exactly.
  generate
    if (SRAM_DELAY == 0) begin : g_nodly
      assign w_rd_vld_0 = w_rd_ok_0;
      assign w_rd_vld_1 = w_rd_ok_1;
    end else begin : g_dly
      logic [SRAM_DELAY-1:0] r_vld_0;
      logic [SRAM_DELAY-1:0] r_vld_1;

      // Shift forwarded read enables down the latency pipeline; reset drops in-flight reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld_0 <= '0;
          r_vld_1 <= '0;
        end else begin
          r_vld_0 <= SRAM_DELAY'({r_vld_0, w_rd_ok_0});
          r_vld_1 <= SRAM_DELAY'({r_vld_1, w_rd_ok_1});
        end
      end

      assign w_rd_vld_0 = r_vld_0[SRAM_DELAY-1];
      assign w_rd_vld_1 = r_vld_1[SRAM_DELAY-1];
    end
  endgenerate

  assign io_bus.rd_vld_0  = w_rd_vld_0;
  assign io_bus.rd_vld_1  = w_rd_vld_1;
  assign io_bus.rd_dout_0 = w_rd_vld_0 ? io_bus.mem_rd_dout_0 : '0;
  assign io_bus.rd_dout_1 = w_rd_vld_1 ? io_bus.mem_rd_dout_1 : '0;

endmodule

// File: tb/tb_atom_2r2w_ctrl.sv
// tb_atom_2r2w_ctrl: two controller instances (5 words / zero latency, 8 words / 2-cycle latency) on behavioural atoms.
// Latency: n/a.
// Backpressure: n/a.
module tb_atom_2r2w_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  atom_2r2w_ctrl_if #(.BITADDR(3), .BITDATA(4)) ba ();
  atom_2r2w_ctrl_if #(.BITADDR(3), .BITDATA(4)) bb ();

  atom_2r2w_ctrl #(.NUMADDR(5), .BITADDR(3), .BITDATA(4), .SRAM_DELAY(0),
                   .RSTINIT(1), .RSTSTRT(3), .RSTINCR(2))
    u_a (.clk(clk), .rst(rst), .io_bus(ba));

  atom_2r2w_ctrl #(.NUMADDR(8), .BITADDR(3), .BITDATA(4), .SRAM_DELAY(2),
                   .RSTINIT(1), .RSTSTRT(14), .RSTINCR(1))
    u_b (.clk(clk), .rst(rst), .io_bus(bb));

  // behavioural atoms: A reads combinationally, B through a 2-stage data pipe
  logic [3:0] mem_a [8];
  logic [3:0] mem_b [8];
  logic [3:0] pb0 [2];
  logic [3:0] pb1 [2];

  always @(posedge clk) begin
    if (ba.mem_write_2) mem_a[ba.mem_wr_adr_2] <= ba.mem_wr_din_2;
    if (ba.mem_write_3) mem_a[ba.mem_wr_adr_3] <= ba.mem_wr_din_3;
    if (bb.mem_write_2) mem_b[bb.mem_wr_adr_2] <= bb.mem_wr_din_2;
    if (bb.mem_write_3) mem_b[bb.mem_wr_adr_3] <= bb.mem_wr_din_3;
    pb0[0] <= mem_b[bb.mem_rd_adr_0];
    pb0[1] <= pb0[0];
    pb1[0] <= mem_b[bb.mem_rd_adr_1];
    pb1[1] <= pb1[0];
  end

  assign ba.mem_rd_dout_0 = mem_a[ba.mem_rd_adr_0];
  assign ba.mem_rd_dout_1 = mem_a[ba.mem_rd_adr_1];
  assign bb.mem_rd_dout_0 = pb0[1];
  assign bb.mem_rd_dout_1 = pb1[1];

  // expected memory images
  logic [3:0] init_a [8] = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd0, 4'd0, 4'd0};
  logic [3:0] init_b [8] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  logic [3:0] ref_a  [8];
  logic [3:0] ref_b  [8];

  // scoreboards of expected read data per port
  logic [3:0] q_a0 [$];
  logic [3:0] q_a1 [$];
  logic [3:0] q_b0 [$];
  logic [3:0] q_b1 [$];

  typedef struct {
    int rd0; int a0; int rd1; int a1;
    int wr2; int w2a; int w2d;
    int wr3; int w3a; int w3d;
    int e_mr0; int e_mr1; int e_mw2; int e_mw3; int e_oor;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_init(input string tag, input int k, input int n,
                          input logic w2, input logic [2:0] a2, input logic [3:0] d2,
                          input logic w3, input logic [2:0] a3, input logic [3:0] d3,
                          input logic rdy, input logic [3:0] e2, input logic [3:0] e3);
    bit has3;
    has3 = (2 * k + 1) < n;
    chk({tag, "_w2"},  w2, 1);
    chk({tag, "_a2"},  a2, 2 * k);
    chk({tag, "_d2"},  d2, e2);
    chk({tag, "_w3"},  w3, has3);
    chk({tag, "_a3"},  a3, has3 ? 2 * k + 1 : 0);
    chk({tag, "_d3"},  d3, has3 ? e3 : 4'd0);
    chk({tag, "_rdy"}, rdy, 0);
  endtask

  task automatic idle_a();
    ba.read_0 = 0; ba.read_1 = 0; ba.write_2 = 0; ba.write_3 = 0;
    ba.rd_adr_0 = 0; ba.rd_adr_1 = 0; ba.wr_adr_2 = 0; ba.wr_adr_3 = 0;
    ba.wr_din_2 = 0; ba.wr_din_3 = 0;
  endtask

  task automatic idle_b();
    bb.read_0 = 0; bb.read_1 = 0; bb.write_2 = 0; bb.write_3 = 0;
    bb.rd_adr_0 = 0; bb.rd_adr_1 = 0; bb.wr_adr_2 = 0; bb.wr_adr_3 = 0;
    bb.wr_din_2 = 0; bb.wr_din_3 = 0;
  endtask

  // read-return monitor, sampled well clear of both clock edges
  always @(negedge clk) begin
    #3;
    if (ba.rd_vld_0) begin
      if (q_a0.size() == 0) chk("a0_spurious_vld", ba.rd_vld_0, 0);
      else chk("a0_rd_dout", ba.rd_dout_0, q_a0.pop_front());
    end else chk("a0_dout_idle", ba.rd_dout_0, 0);
    if (ba.rd_vld_1) begin
      if (q_a1.size() == 0) chk("a1_spurious_vld", ba.rd_vld_1, 0);
      else chk("a1_rd_dout", ba.rd_dout_1, q_a1.pop_front());
    end else chk("a1_dout_idle", ba.rd_dout_1, 0);
    if (bb.rd_vld_0) begin
      if (q_b0.size() == 0) chk("b0_spurious_vld", bb.rd_vld_0, 0);
      else chk("b0_rd_dout", bb.rd_dout_0, q_b0.pop_front());
    end else chk("b0_dout_idle", bb.rd_dout_0, 0);
    if (bb.rd_vld_1) begin
      if (q_b1.size() == 0) chk("b1_spurious_vld", bb.rd_vld_1, 0);
      else chk("b1_rd_dout", bb.rd_dout_1, q_b1.pop_front());
    end else chk("b1_dout_idle", bb.rd_dout_1, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_oor;
    vec_t v;

    //             rd0 a0 rd1 a1  wr2 w2a w2d  wr3 w3a w3d  mr0 mr1 mw2 mw3 oor
    tbl[0]  = '{1, 0, 1, 1,  0, 0, 0,   0, 0, 0,   1, 1, 0, 0, 0};
    tbl[1]  = '{1, 2, 1, 3,  0, 0, 0,   0, 0, 0,   1, 1, 0, 0, 0};
    tbl[2]  = '{1, 4, 1, 4,  0, 0, 0,   0, 0, 0,   1, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 7,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 1};
    tbl[4]  = '{1, 5, 0, 0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 0,  1, 1, 12,  1, 2, 6,   1, 0, 1, 1, 0};
    tbl[6]  = '{1, 1, 1, 2,  0, 0, 0,   0, 0, 0,   1, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,  1, 3, 1,   1, 3, 2,   0, 0, 0, 1, 0};
    tbl[8]  = '{1, 3, 0, 0,  0, 0, 0,   0, 0, 0,   1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,  1, 6, 15,  1, 0, 8,   0, 0, 0, 1, 1};
    tbl[10] = '{0, 0, 1, 0,  0, 0, 0,   1, 5, 9,   0, 1, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0};
    tbl[12] = '{1, 4, 1, 4,  0, 0, 0,   0, 0, 0,   1, 1, 0, 0, 0};

    for (int i = 0; i < 8; i++) begin
      ref_a[i] = init_a[i];
      ref_b[i] = init_b[i];
    end

    idle_a();
    idle_b();
    rst = 1'b0;
    #1 rst = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_a", ba.ready, 0);
    chk("rst_ready_b", bb.ready, 0);
    chk("rst_mw2_a", ba.mem_write_2, 0);
    chk("rst_mw3_a", ba.mem_write_3, 0);
    chk("rst_mw2_b", bb.mem_write_2, 0);
    chk("rst_oor_a", ba.oor_err, 0);
    chk("rst_vld_b0", bb.rd_vld_0, 0);

    // requests during reset/INIT must be dropped silently
    ba.read_0 = 1; ba.rd_adr_0 = 1;
    ba.read_1 = 1; ba.rd_adr_1 = 7;

    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        chk_init("init_a", k, 5, ba.mem_write_2, ba.mem_wr_adr_2, ba.mem_wr_din_2,
                 ba.mem_write_3, ba.mem_wr_adr_3, ba.mem_wr_din_3, ba.ready,
                 init_a[2 * k], init_a[2 * k + 1]);
        chk("init_a_mr0", ba.mem_read_0, 0);
        chk("init_a_mr1", ba.mem_read_1, 0);
        chk("init_a_oor", ba.oor_err, 0);
        chk("init_a_vld0", ba.rd_vld_0, 0);
      end else begin
        chk("init_a_ready", ba.ready, 1);
      end
      if (k < 4)
        chk_init("init_b", k, 8, bb.mem_write_2, bb.mem_wr_adr_2, bb.mem_wr_din_2,
                 bb.mem_write_3, bb.mem_wr_adr_3, bb.mem_wr_din_3, bb.ready,
                 init_b[2 * k], init_b[2 * k + 1]);
      else
        chk("init_b_ready", bb.ready, 1);
      if (k == 2) idle_a();
      @(negedge clk);
      #1;
    end

    // table-driven traffic on instance A
    prev_oor = 0;
    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      ba.read_0  = 1'(v.rd0); ba.rd_adr_0 = 3'(v.a0);
      ba.read_1  = 1'(v.rd1); ba.rd_adr_1 = 3'(v.a1);
      ba.write_2 = 1'(v.wr2); ba.wr_adr_2 = 3'(v.w2a); ba.wr_din_2 = 4'(v.w2d);
      ba.write_3 = 1'(v.wr3); ba.wr_adr_3 = 3'(v.w3a); ba.wr_din_3 = 4'(v.w3d);
      if (v.e_mr0 != 0) q_a0.push_back(ref_a[v.a0]);
      if (v.e_mr1 != 0) q_a1.push_back(ref_a[v.a1]);
      #1;
      chk($sformatf("v%0d_mem_read_0", i),   ba.mem_read_0,   v.e_mr0);
      chk($sformatf("v%0d_mem_read_1", i),   ba.mem_read_1,   v.e_mr1);
      chk($sformatf("v%0d_mem_write_2", i),  ba.mem_write_2,  v.e_mw2);
      chk($sformatf("v%0d_mem_write_3", i),  ba.mem_write_3,  v.e_mw3);
      chk($sformatf("v%0d_mem_rd_adr_0", i), ba.mem_rd_adr_0, (v.e_mr0 != 0) ? v.a0 : 0);
      chk($sformatf("v%0d_mem_rd_adr_1", i), ba.mem_rd_adr_1, (v.e_mr1 != 0) ? v.a1 : 0);
      chk($sformatf("v%0d_mem_wr_adr_2", i), ba.mem_wr_adr_2, (v.e_mw2 != 0) ? v.w2a : 0);
      chk($sformatf("v%0d_mem_wr_din_2", i), ba.mem_wr_din_2, (v.e_mw2 != 0) ? v.w2d : 0);
      chk($sformatf("v%0d_mem_wr_adr_3", i), ba.mem_wr_adr_3, (v.e_mw3 != 0) ? v.w3a : 0);
      chk($sformatf("v%0d_mem_wr_din_3", i), ba.mem_wr_din_3, (v.e_mw3 != 0) ? v.w3d : 0);
      chk($sformatf("v%0d_oor_prev", i),     ba.oor_err,      prev_oor);
      if (v.e_mw2 != 0) ref_a[v.w2a] = 4'(v.w2d);
      if (v.e_mw3 != 0) ref_a[v.w3a] = 4'(v.w3d);
      prev_oor = v.e_oor;
      @(negedge clk);
      #1;
    end
    idle_a();
    chk("tbl_oor_last", ba.oor_err, prev_oor);
    @(negedge clk);
    #1;

    // B: back-to-back reads of adr 3 with 2-cycle latency
    bb.read_0 = 1; bb.rd_adr_0 = 3; q_b0.push_back(ref_b[3]);
    #1 chk("b_lat_fwd_t0", bb.mem_read_0, 1);
    chk("b_lat_vld_t0", bb.rd_vld_0, 0);
    @(negedge clk); #1;
    q_b0.push_back(ref_b[3]);
    #1 chk("b_lat_vld_t1", bb.rd_vld_0, 0);
    @(negedge clk); #1;
    idle_b();
    #1 chk("b_lat_vld_t2", bb.rd_vld_0, 1);
    @(negedge clk); #1;
    #1 chk("b_lat_vld_t3", bb.rd_vld_0, 1);
    @(negedge clk); #1;
    #1 chk("b_lat_vld_t4", bb.rd_vld_0, 0);
    @(negedge clk); #1;

    // B: full read sweep through both ports (includes wrapped init values)
    for (int a = 0; a < 8; a += 2) begin
      bb.read_0 = 1; bb.rd_adr_0 = 3'(a);     q_b0.push_back(ref_b[a]);
      bb.read_1 = 1; bb.rd_adr_1 = 3'(a + 1); q_b1.push_back(ref_b[a + 1]);
      @(negedge clk); #1;
    end
    idle_b();
    repeat (3) begin @(negedge clk); #1; end

    // B: same-address write collision, port 3 must win
    bb.write_2 = 1; bb.wr_adr_2 = 6; bb.wr_din_2 = 4'hA;
    bb.write_3 = 1; bb.wr_adr_3 = 6; bb.wr_din_3 = 4'h5;
    #1;
    chk("coll_mw2", bb.mem_write_2, 0);
    chk("coll_mw3", bb.mem_write_3, 1);
    chk("coll_adr3", bb.mem_wr_adr_3, 6);
    chk("coll_din3", bb.mem_wr_din_3, 5);
    ref_b[6] = 4'h5;
    @(negedge clk); #1;
    idle_b();
    bb.read_0 = 1; bb.rd_adr_0 = 6; q_b0.push_back(ref_b[6]);
    @(negedge clk); #1;
    idle_b();
    repeat (3) begin @(negedge clk); #1; end

    // reset with a B read in flight, then reset again on A's INIT cycle 1
    bb.read_0 = 1; bb.rd_adr_0 = 2;
    #1 chk("inflight_fwd", bb.mem_read_0, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    idle_b();
    #1;
    chk("mid_rst_ready_a", ba.ready, 0);
    chk("mid_rst_mw2_a", ba.mem_write_2, 0);
    chk("mid_rst_mw3_a", ba.mem_write_3, 0);
    chk("mid_rst_vld_b0", bb.rd_vld_0, 0);
    @(negedge clk); #1;
    chk("inflight_lost", bb.rd_vld_0, 0);
    rst = 1'b0;
    #1;
    chk_init("rst1_a", 0, 5, ba.mem_write_2, ba.mem_wr_adr_2, ba.mem_wr_din_2,
             ba.mem_write_3, ba.mem_wr_adr_3, ba.mem_wr_din_3, ba.ready, init_a[0], init_a[1]);
    @(negedge clk); #1;
    chk("inflight_lost_late", bb.rd_vld_0, 0);
    chk_init("rst1_a", 1, 5, ba.mem_write_2, ba.mem_wr_adr_2, ba.mem_wr_din_2,
             ba.mem_write_3, ba.mem_wr_adr_3, ba.mem_wr_din_3, ba.ready, init_a[2], init_a[3]);
    rst = 1'b1;
    #1;
    chk("init_rst_mw2_a", ba.mem_write_2, 0);
    chk("init_rst_mw3_a", ba.mem_write_3, 0);
    chk("init_rst_ready_a", ba.ready, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3)
        chk_init("rst2_a", k, 5, ba.mem_write_2, ba.mem_wr_adr_2, ba.mem_wr_din_2,
                 ba.mem_write_3, ba.mem_wr_adr_3, ba.mem_wr_din_3, ba.ready,
                 init_a[2 * k], init_a[2 * k + 1]);
      else
        chk("rst2_a_ready", ba.ready, 1);
      @(negedge clk); #1;
    end

    chk("sb_empty", q_a0.size() + q_a1.size() + q_b0.size() + q_b1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
